// File: rtl/tdm_demux1x8_if.sv
// tdm_demux1x8_if: serial-slot input and parallel-frame output bundle; ch_upd only with DEMUX_STROBE_EN
interface tdm_demux1x8_if #(parameter int W = 1);
    logic [W-1:0]   din;
    logic           din_valid;
    logic           frame_start;
    logic [8*W-1:0] y;
    logic [2:0]     slot;
    logic           locked;
    logic           frame_done;
    logic           frame_err;
`ifdef DEMUX_STROBE_EN
    logic [7:0]     ch_upd;
`endif
    modport master (
        output din, din_valid, frame_start,
        input  y, slot, locked, frame_done, frame_err
`ifdef DEMUX_STROBE_EN
        , input ch_upd
`endif
    );
    modport slave (
        input  din, din_valid, frame_start,
        output y, slot, locked, frame_done, frame_err
`ifdef DEMUX_STROBE_EN
        , output ch_upd
`endif
    );
endinterface

// File: rtl/tdm_demux1x8.sv
// tdm_demux1x8: 1-to-8 TDM slot demultiplexer publishing whole frames; DEMUX_STROBE_EN adds per-channel update strobes
module tdm_demux1x8 #(
    parameter int W = 1
) (
    input logic           clk,
    input logic           rst,
    tdm_demux1x8_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t         state, state_nx;
    logic [W-1:0]   shadow [7];
    logic           accept;
    logic           err_nx;
    logic           done_nx;
    logic [2:0]     wr_idx;
    logic [2:0]     slot_nx;
    logic [7:0]     upd_nx;
    logic [8*W-1:0] frame_nx;

    assign bus.locked = (state == RUN);

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // lock on the first frame-start beat; only reset leaves RUN
    always_comb begin
        state_nx = (state == IDLE && bus.din_valid && bus.frame_start) ? RUN : state;
    end

    // beat decode: slot 7 never lands in the shadow, it goes straight into the published frame
    always_comb begin
        accept   = bus.din_valid && (state == RUN || bus.frame_start);
        err_nx   = state == RUN && bus.din_valid && bus.frame_start && bus.slot != 3'd0;
        wr_idx   = (state == IDLE || err_nx) ? 3'd0 : bus.slot;
        slot_nx  = accept ? wr_idx + 3'd1 : bus.slot;
        done_nx  = accept && wr_idx == 3'd7;
        upd_nx   = accept ? 8'd1 << wr_idx : 8'd0;
        frame_nx = '0;
        for (int k = 0; k < 7; k++) frame_nx[k*W +: W] = shadow[k];
        frame_nx[7*W +: W] = bus.din;
    end

    // shadow buffer, published frame, slot pointer and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 7; k++) shadow[k] <= '0;
            bus.y          <= '0;
            bus.slot       <= 3'd0;
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            for (int k = 0; k < 7; k++) if (accept && wr_idx == 3'(k)) shadow[k] <= bus.din;
            if (done_nx) bus.y <= frame_nx;
            bus.slot       <= slot_nx;
            bus.frame_done <= done_nx;
            bus.frame_err  <= err_nx;
        end
    end

`ifdef DEMUX_STROBE_EN
    // one-hot strobe for the channel written on the previous edge
    always_ff @(posedge clk) begin
        bus.ch_upd <= rst ? 8'd0 : upd_nx;
    end
`else
    logic unused_upd;
    assign unused_upd = ^upd_nx;
`endif

    // an errored beat is always slot 0, so it can never complete a frame
    a_no_done_with_err: assert property (@(posedge clk) disable iff (rst) !(bus.frame_done && bus.frame_err));
endmodule

// File: doc/tdm_demux1x8.md
# tdm_demux1x8

Time-division 1-to-8 demultiplexer, the receive end of the team's 8:1 multiplexer used as a slot serializer. Accepts a stream of W-bit samples, one per qualified beat, tagged by a frame-start marker on slot 0. Steers each sample into one of eight channel registers and publishes all eight channels together once a frame is complete. Sits between a serialized link and the parallel channel logic.

## Interface
- W, default 1: width of one slot sample in bits.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- din  input  W  sample for the current slot.
- din_valid  input  1  qualifies din and frame_start for this cycle.
- frame_start  input  1  marks the din beat as slot 0; ignored when din_valid=0.
- y  output  8*W  published channels; channel k is y[k*W +: W].
- slot  output  3  index the next valid beat will be written to.
- locked  output  1  high while in state RUN.
- frame_done  output  1  one-cycle pulse: y updated with a complete frame.
- frame_err  output  1  one-cycle pulse: frame_start seen on a beat whose expected slot is not 0.
- ch_upd  output  8  per-channel update strobe (only with DEMUX_STROBE_EN).

## Operation
- Reset (rst=1 at a rising edge): state IDLE; slot=0; shadow buffer=0; y=0; locked=0; frame_done=0; frame_err=0; ch_upd=0. A partial frame is discarded. rst has priority over every other input.
- Two states: IDLE and RUN. locked = (state==RUN).
- IDLE:
  - A beat with din_valid=1 and frame_start=1 writes din to shadow[0], sets slot=1, and moves to RUN.
  - Beats without frame_start are dropped. slot stays 0.
- RUN, beat with din_valid=1:
  - frame_start=0: write din to shadow[slot], then slot=slot+1 (mod 8).
  - frame_start=1 and slot==0: normal frame start, same as frame_start=0.
  - frame_start=1 and slot!=0: pulse frame_err. Discard the partial frame (previous shadow contents are not published). Write din to shadow[0]. Set slot=1. Stay in RUN.
  - When the beat written is slot 7, copy shadow[0..6] and din into y in the same edge, pulse frame_done, and wrap slot to 0.
- din_valid=0: no state change. Gaps are allowed anywhere in a frame.
- y holds its last published frame until the next complete frame. Partial frames never reach y.
- There is no return from RUN to IDLE except through rst.

## Timing
- All outputs are registered.
- Latency: y and frame_done change at the edge that samples the slot-7 beat. They are visible in the following cycle.
- frame_done and frame_err are single-cycle pulses. With back-to-back frames, frame_done can pulse once every 8 valid cycles.
- frame_err and frame_done never assert together, because an errored beat is always written as slot 0.
- Minimum frame is 8 consecutive valid cycles. Throughput is one sample per cycle.

## Configuration
- Macro: DEMUX_STROBE_EN.
- Defined:
  - ch_upd exists. ch_upd[k] pulses for one cycle after the edge that writes slot k into the shadow buffer.
  - Reset value of ch_upd is 0.
  - On a frame_err beat, ch_upd[0] pulses.
- Undefined: the ch_upd port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst=1 for 2 cycles during activity. Required: y=0, slot=0, locked=0, frame_done=0, frame_err=0.
- Clean frame, W=1: after rst, drive 8 valid beats with din=1,0,1,1,0,0,1,0 and frame_start on the first beat. Required: y=8'b01001101 the cycle after beat 8; frame_done high for exactly that cycle; slot returns to 0.
- Gaps: same frame with din_valid=0 for 3 cycles between slots 3 and 4. Required: same y, and frame_done is delayed by 3 cycles.
- Unlocked input: 5 valid beats with frame_start=0 after reset. Required: locked stays 0, slot stays 0, y stays 0.
- Mid-frame resync: start a frame and send 4 beats, then frame_start with din=1 followed by 7 beats of 0. Required: frame_err pulses once at the resync beat; a single frame_done pulses with y=8'b00000001; the partial frame never appears on y.
- Reset mid-frame, W=4: publish a frame with y=32'h76543210, send 3 beats of a new frame, then rst=1. Required: y=0 and locked=0. The next frame publishes correctly. With DEMUX_STROBE_EN, ch_upd pulses in sequence 0 through 7.
